// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states and
// instruction field positions.
package cpu_pkg;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OP_NOP  = 5'd0;
  localparam opcode_t OP_ADD  = 5'd1;
  localparam opcode_t OP_SUB  = 5'd2;
  localparam opcode_t OP_AND  = 5'd3;
  localparam opcode_t OP_OR   = 5'd4;
  localparam opcode_t OP_XOR  = 5'd5;
  localparam opcode_t OP_SHL  = 5'd6;
  localparam opcode_t OP_SHR  = 5'd7;
  localparam opcode_t OP_LD   = 5'd8;
  localparam opcode_t OP_ST   = 5'd9;
  localparam opcode_t OP_BEQ  = 5'd10;
  localparam opcode_t OP_BNE  = 5'd11;
  localparam opcode_t OP_JMP  = 5'd12;
  localparam opcode_t OP_IN   = 5'd13;
  localparam opcode_t OP_OUT  = 5'd14;
  localparam opcode_t OP_HALT = 5'd15;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_HALT
  } state_t;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 27;
  localparam int DEST_LO  = 22;
  localparam int SRC1_LO  = 17;
  localparam int IMMF_BIT = 16;
  localparam int SRC2_LO  = 11;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;

  // ALU opcodes that write dest and update the flags (NOP excluded).
  function automatic logic is_alu_op(opcode_t op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/multicycle_cpu_core_if.sv
// Data-memory request/ready bus between the core (master) and the data
// memory (slave).
interface multicycle_cpu_core_if #(
  parameter int DATA_W  = 16,
  parameter int DADDR_W = 8
) ();
  logic               dmem_req;
  logic               dmem_we;
  logic [DADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic [DATA_W-1:0]  dmem_rdata;
  logic               dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU: add/sub with carry and signed overflow, logic ops and
// shifts, plus zero/sign of the result.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  opcode_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              overflow,
  output logic              sign
);
  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;
  localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

  logic [DATA_W:0] sum;
  logic [DATA_W:0] shl_ext;
  logic [SH_W-1:0] shamt;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned, which would otherwise infer a latch.
    shamt    = b[SH_W-1:0];
    sum      = '0;
    shl_ext  = '0;
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        sum      = {1'b0, a} + {1'b0, b};
        result   = sum[MSB:0];
        carry    = sum[DATA_W];
        overflow = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_SUB: begin
        // carry is the raw carry-out of a + ~b + 1, so 0 signals a borrow
        sum      = {1'b0, a} + {1'b0, ~b} + ONE;
        result   = sum[MSB:0];
        carry    = sum[DATA_W];
        overflow = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        shl_ext = {1'b0, a} << shamt;
        result  = shl_ext[MSB:0];
        carry   = shl_ext[DATA_W];
      end
      OP_SHR: result = a >> shamt;
      default: ;
    endcase
    zero = (result == '0);
    sign = result[MSB];
  end

endmodule

// File: rtl/multicycle_cpu_core.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM processor with register file, flags,
// branches, request/ready data memory access, I/O port and halt.
module multicycle_cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 32,
  parameter int PC_W     = 8,
  parameter int DADDR_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [PC_W-1:0]       imem_addr,
  input  logic [31:0]           imem_rdata,
  multicycle_cpu_core_if.master dmem,
  input  logic [DATA_W-1:0]     in_data,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  output logic [3:0]            flags,
  output logic                  halted,
  output logic                  illegal
);
  localparam int RIDX_W = $clog2(NUM_REGS);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_inc, target;
  logic [31:0]       ir_q;
  logic [DATA_W-1:0] regs [NUM_REGS];

  opcode_t           op;
  logic [RIDX_W-1:0] dest_idx, src1_idx, src2_idx;
  logic signed [15:0] imm_s;
  logic [DATA_W-1:0] imm_ext, src1_val, src2_val, op_b, addr_sum;
  logic [DATA_W-1:0] alu_result, wb_data;
  logic              alu_carry, alu_zero, alu_ovf, alu_sign, wb_en;

  assign op       = ir_q[OP_HI:OP_LO];
  assign dest_idx = ir_q[DEST_LO +: RIDX_W];
  assign src1_idx = ir_q[SRC1_LO +: RIDX_W];
  assign src2_idx = ir_q[SRC2_LO +: RIDX_W];
  assign imm_s    = ir_q[IMM_HI:IMM_LO];
  assign imm_ext  = DATA_W'(imm_s);

  // Operands are read from IR while it is stable through EXECUTE and MEM.
  assign src1_val = (src1_idx == '0) ? '0 : regs[src1_idx];
  assign src2_val = (src2_idx == '0) ? '0 : regs[src2_idx];
  assign op_b     = ir_q[IMMF_BIT] ? imm_ext : src2_val;
  assign addr_sum = src1_val + imm_ext;
  assign pc_inc   = pc_q + PC_W'(1);
  assign target   = ir_q[PC_W-1:0];

  assign imem_addr     = pc_q;
  assign dmem.dmem_req = (state_q == S_MEM);
  assign halted        = (state_q == S_HALT);

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op       (op),
    .a        (src1_val),
    .b        (op_b),
    .result   (alu_result),
    .carry    (alu_carry),
    .zero     (alu_zero),
    .overflow (alu_ovf),
    .sign     (alu_sign)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (op[4] || op == OP_HALT)       state_d = S_HALT;
        else if (op == OP_LD || op == OP_ST) state_d = S_MEM;
        else                              state_d = S_FETCH;
      end
      S_MEM:     if (dmem.dmem_ready) state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    wb_en   = 1'b0;
    wb_data = alu_result;
    if (state_q == S_EXECUTE && (is_alu_op(op) || op == OP_IN)) begin
      wb_en = 1'b1;
      if (op == OP_IN) wb_data = in_data;
    end else if (state_q == S_MEM && dmem.dmem_ready && !dmem.dmem_we) begin
      wb_en   = 1'b1;
      wb_data = dmem.dmem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q            <= '0;
      ir_q            <= '0;
      flags           <= '0;
      out_data        <= '0;
      out_valid       <= 1'b0;
      illegal         <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      // NOTE: the register file is cleared on reset, so it is built from
      // flops rather than a RAM macro.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (wb_en && dest_idx != '0) regs[dest_idx] <= wb_data;
      case (state_q)
        S_DECODE: ir_q <= imem_rdata;
        S_EXECUTE: begin
          if (is_alu_op(op)) flags <= {alu_carry, alu_zero, alu_ovf, alu_sign};
          case (op)
            OP_LD, OP_ST: begin
              dmem.dmem_we    <= (op == OP_ST);
              dmem.dmem_addr  <= DADDR_W'(addr_sum);
              dmem.dmem_wdata <= src2_val;
            end
            OP_BEQ:  pc_q <= flags[2] ? target : pc_inc;
            OP_BNE:  pc_q <= flags[2] ? pc_inc : target;
            OP_JMP:  pc_q <= target;
            OP_OUT: begin
              out_data  <= src1_val;
              out_valid <= 1'b1;
              pc_q      <= pc_inc;
            end
            OP_HALT: ;
            OP_NOP:  pc_q <= pc_inc;
            default: begin
              if (op[4]) illegal <= 1'b1;
              else       pc_q <= pc_inc;
            end
          endcase
        end
        S_MEM: if (dmem.dmem_ready) pc_q <= pc_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Directed bench for multicycle_cpu_core: small programs in a behavioural
// instruction/data memory, checked against hand-computed results.
module tb_multicycle_cpu_core;
  import cpu_pkg::*;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 32;
  localparam int PC_W     = 8;
  localparam int DADDR_W  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [PC_W-1:0]   imem_addr;
  logic [31:0]       imem_rdata;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [3:0]        flags;
  logic              halted;
  logic              illegal;

  multicycle_cpu_core_if #(.DATA_W(DATA_W), .DADDR_W(DADDR_W)) dmem_bus ();

  multicycle_cpu_core #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .PC_W(PC_W), .DADDR_W(DADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem       (dmem_bus),
    .in_data    (in_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .flags      (flags),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle read latency.
  logic [31:0] imem [0:255];
  always @(posedge clk) imem_rdata <= imem[imem_addr];

  // Data memory: ready after wait_cycles cycles of request.
  logic [DATA_W-1:0] dmem_mem [0:255];
  int wait_cycles;
  int wait_cnt = 0;
  assign dmem_bus.dmem_ready = dmem_bus.dmem_req && (wait_cnt == wait_cycles);
  assign dmem_bus.dmem_rdata = dmem_mem[dmem_bus.dmem_addr];
  always @(posedge clk) begin
    if (dmem_bus.dmem_req && !dmem_bus.dmem_ready) wait_cnt <= wait_cnt + 1;
    else                                           wait_cnt <= 0;
    if (dmem_bus.dmem_req && dmem_bus.dmem_ready && dmem_bus.dmem_we)
      dmem_mem[dmem_bus.dmem_addr] <= dmem_bus.dmem_wdata;
  end

  // Access log: one entry per completed access, with its request length.
  int                 acc_n = 0;
  int                 acc_len_cur = 0;
  logic               acc_we    [0:15];
  int                 acc_len   [0:15];
  logic [DADDR_W-1:0] acc_addr  [0:15];
  logic [DATA_W-1:0]  acc_wdata [0:15];
  always @(negedge clk) begin
    if (dmem_bus.dmem_req) begin
      if (dmem_bus.dmem_ready) begin
        if (acc_n < 16) begin
          acc_we[acc_n]    = dmem_bus.dmem_we;
          acc_len[acc_n]   = acc_len_cur + 1;
          acc_addr[acc_n]  = dmem_bus.dmem_addr;
          acc_wdata[acc_n] = dmem_bus.dmem_wdata;
        end
        acc_n++;
        acc_len_cur = 0;
      end else begin
        acc_len_cur++;
      end
    end else begin
      acc_len_cur = 0;
    end
  end

  // Output log: value and flags seen on each out_valid pulse.
  int                out_n = 0;
  logic [DATA_W-1:0] out_log  [0:31];
  logic [3:0]        flag_log [0:31];
  always @(negedge clk) begin
    if (out_valid) begin
      if (out_n < 32) begin
        out_log[out_n]  = out_data;
        flag_log[out_n] = flags;
      end
      out_n++;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(opcode_t op, logic [4:0] d, logic [4:0] s1,
                                        logic [15:0] imm);
    return {op, d, s1, 1'b1, imm};
  endfunction

  function automatic logic [31:0] enc_r(opcode_t op, logic [4:0] d, logic [4:0] s1,
                                        logic [4:0] s2);
    return {op, d, s1, 1'b0, s2, 11'd0};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = enc_r(OP_HALT, 5'd0, 5'd0, 5'd0);
  endtask

  // Leaves the bench at the falling edge of cycle 1 (first FETCH).
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_halt(input int budget, input string tag);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, halted, 1'b1);
  endtask

  int ob, ab;

  initial begin
    in_data     = 16'h00A5;
    wait_cycles = 0;

    // ADD imm, ADD reg, OUT, HALT
    clear_imem();
    imem[0] = enc_i(OP_ADD, 5'd1, 5'd0, 16'd5);
    imem[1] = enc_r(OP_ADD, 5'd2, 5'd1, 5'd1);
    imem[2] = enc_r(OP_OUT, 5'd0, 5'd2, 5'd0);
    imem[3] = enc_r(OP_HALT, 5'd0, 5'd0, 5'd0);
    ob = out_n;
    do_reset();
    check("rst_imem_addr", imem_addr, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_dmem_req", dmem_bus.dmem_req, 0);
    check("rst_flags", flags, 4'b0000);
    check("rst_out_data", out_data, 0);
    repeat (11) @(negedge clk);
    check("add_halted_c12", halted, 0);
    @(negedge clk);
    check("add_halted_c13", halted, 1);
    check("add_pulses", out_n - ob, 1);
    check("add_out_log", out_log[ob], 16'd10);
    check("add_out_data", out_data, 16'd10);
    check("add_zero_flag", flags[2], 0);

    // Overflow, borrow, shifts, XOR
    clear_imem();
    imem[0]  = enc_i(OP_ADD, 5'd1, 5'd0, 16'h7FFF);
    imem[1]  = enc_i(OP_ADD, 5'd2, 5'd1, 16'd1);
    imem[2]  = enc_r(OP_OUT, 5'd0, 5'd2, 5'd0);
    imem[3]  = enc_i(OP_SUB, 5'd3, 5'd0, 16'd1);
    imem[4]  = enc_r(OP_OUT, 5'd0, 5'd3, 5'd0);
    imem[5]  = enc_i(OP_SHL, 5'd4, 5'd2, 16'd1);
    imem[6]  = enc_r(OP_OUT, 5'd0, 5'd4, 5'd0);
    imem[7]  = enc_i(OP_SHR, 5'd5, 5'd3, 16'd4);
    imem[8]  = enc_r(OP_OUT, 5'd0, 5'd5, 5'd0);
    imem[9]  = enc_r(OP_XOR, 5'd6, 5'd5, 5'd3);
    imem[10] = enc_r(OP_OUT, 5'd0, 5'd6, 5'd0);
    ob = out_n;
    do_reset();
    wait_halt(100, "ovf_halt");
    check("ovf_pulses", out_n - ob, 5);
    check("ovf_add_res", out_log[ob], 16'h8000);
    check("ovf_add_flags", flag_log[ob], 4'b0011);
    check("sub_res", out_log[ob+1], 16'hFFFF);
    check("sub_flags", flag_log[ob+1], 4'b0001);
    check("shl_res", out_log[ob+2], 16'h0000);
    check("shl_flags", flag_log[ob+2], 4'b1100);
    check("shr_res", out_log[ob+3], 16'h0FFF);
    check("shr_flags", flag_log[ob+3], 4'b0000);
    check("xor_res", out_log[ob+4], 16'hF000);
    check("xor_flags", flag_log[ob+4], 4'b0001);

    // Store then load with two wait cycles per access
    wait_cycles = 2;
    clear_imem();
    imem[0] = enc_i(OP_ADD, 5'd1, 5'd0, 16'h1234);
    imem[1] = enc_r(OP_ST, 5'd0, 5'd0, 5'd1) | 32'd3;
    imem[2] = enc_i(OP_LD, 5'd4, 5'd0, 16'd3);
    imem[3] = enc_r(OP_OUT, 5'd0, 5'd4, 5'd0);
    ob = out_n;
    ab = acc_n;
    do_reset();
    repeat (20) @(negedge clk);
    check("mem_halted_c21", halted, 0);
    @(negedge clk);
    check("mem_halted_c22", halted, 1);
    check("mem_acc_count", acc_n - ab, 2);
    check("st_we", acc_we[ab], 1);
    check("st_req_len", acc_len[ab], 3);
    check("st_addr", acc_addr[ab], 8'd3);
    check("st_wdata", acc_wdata[ab], 16'h1234);
    check("ld_we", acc_we[ab+1], 0);
    check("ld_req_len", acc_len[ab+1], 3);
    check("ld_addr", acc_addr[ab+1], 8'd3);
    check("ld_result", out_log[ob], 16'h1234);

    // Branches and pc wrap
    wait_cycles = 0;
    clear_imem();
    imem[0]     = enc_i(OP_ADD, 5'd1, 5'd0, 16'd1);
    imem[1]     = enc_i(OP_BEQ, 5'd0, 5'd0, 16'h0020);
    imem[2]     = enc_i(OP_BNE, 5'd0, 5'd0, 16'h0010);
    imem[8'h10] = enc_r(OP_OUT, 5'd0, 5'd1, 5'd0);
    imem[8'h11] = enc_i(OP_JMP, 5'd0, 5'd0, 16'h00FF);
    imem[8'hFF] = enc_r(OP_NOP, 5'd0, 5'd0, 5'd0);
    ob = out_n;
    do_reset();
    repeat (3) @(negedge clk);
    check("br_c4_addr", imem_addr, 8'h01);
    repeat (3) @(negedge clk);
    check("beq_not_taken", imem_addr, 8'h02);
    repeat (3) @(negedge clk);
    check("bne_taken", imem_addr, 8'h10);
    repeat (3) @(negedge clk);
    check("after_out", imem_addr, 8'h11);
    repeat (3) @(negedge clk);
    check("jmp_taken", imem_addr, 8'hFF);
    repeat (3) @(negedge clk);
    check("pc_wrap", imem_addr, 8'h00);
    check("br_out", out_log[ob], 16'd1);

    // r0 writes ignored, then an undefined opcode
    clear_imem();
    imem[0] = enc_i(OP_ADD, 5'd1, 5'd0, 16'd9);
    imem[1] = enc_r(OP_OUT, 5'd0, 5'd1, 5'd0);
    imem[2] = enc_i(OP_ADD, 5'd0, 5'd0, 16'd7);
    imem[3] = enc_r(OP_OUT, 5'd0, 5'd0, 5'd0);
    imem[4] = enc_r(5'd20, 5'd0, 5'd0, 5'd0);
    ob = out_n;
    do_reset();
    repeat (13) @(negedge clk);
    check("ill_pre_illegal", illegal, 0);
    check("ill_pre_halted", halted, 0);
    repeat (2) @(negedge clk);
    check("ill_illegal", illegal, 1);
    check("ill_halted", halted, 1);
    check("ill_addr", imem_addr, 8'h04);
    check("r0_pulses", out_n - ob, 2);
    check("r1_out", out_log[ob], 16'd9);
    check("r0_out", out_log[ob+1], 16'd0);
    repeat (5) @(negedge clk);
    check("ill_addr_hold", imem_addr, 8'h04);
    check("ill_still_halted", halted, 1);
    check("ill_no_output", out_n - ob, 2);

    // Reset during a memory wait
    wait_cycles = 10;
    clear_imem();
    imem[0] = enc_i(OP_SUB, 5'd1, 5'd0, 16'd1);
    imem[1] = enc_r(OP_OUT, 5'd0, 5'd1, 5'd0);
    imem[2] = enc_r(OP_ST, 5'd0, 5'd0, 5'd1) | 32'd5;
    do_reset();
    ab = acc_n;
    repeat (10) @(negedge clk);
    check("mw_req", dmem_bus.dmem_req, 1);
    check("mw_out_data", out_data, 16'hFFFF);
    check("mw_flags", flags, 4'b0001);
    reset = 1'b0;
    @(negedge clk);
    check("mr_req", dmem_bus.dmem_req, 0);
    check("mr_pc", imem_addr, 8'h00);
    check("mr_illegal", illegal, 0);
    check("mr_flags", flags, 4'b0000);
    check("mr_out_data", out_data, 16'h0000);
    check("mr_out_valid", out_valid, 0);
    check("mr_halted", halted, 0);
    check("mr_no_access", acc_n - ab, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_cpu_core.md
Name: multicycle_cpu_core

Overview:
- Parametrised successor to the fixed 16-bit single-cycle core.
- Multi-cycle FSM processor: fetch, decode, execute, memory. Real branches, load/store over a ready handshake, I/O port instructions, and halt.
- Program memory and data memory are external to this block; the core drives their interfaces.
- Sits under the system top. Replaces the hard-wired register-enable, jump and memory-enable ties of the previous generation.

Parameters:
- DATA_W, 16, datapath/register/ALU width (8..32).
- NUM_REGS, 32, register count (power of 2, ≤32); r0 reads 0, writes ignored.
- PC_W, 8, program counter width; program space 2^PC_W words.
- DADDR_W, 8, data memory address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- imem_addr  out  PC_W  fetch address.
- imem_rdata  in  32  instruction; valid exactly 1 cycle after imem_addr.
- dmem_req  out  1  data access request, held until dmem_ready.
- dmem_we  out  1  1 = store, 0 = load; stable while dmem_req.
- dmem_addr  out  DADDR_W  data address.
- dmem_wdata  out  DATA_W  store data.
- dmem_rdata  in  DATA_W  load data; valid in the dmem_ready cycle.
- dmem_ready  in  1  completes the access in the cycle req&ready.
- in_data  in  DATA_W  external input, sampled by IN.
- out_data  out  DATA_W  output register, written by OUT.
- out_valid  out  1  one-cycle pulse when out_data updates.
- flags  out  4  {carry, zero, overflow, sign}.
- halted  out  1  core in HALT state.
- illegal  out  1  sticky; set on an undefined opcode.

Behaviour:
- Instruction format:
  - [31:27] opcode; [26:22] dest; [21:17] src1; [16] imm_flag; [15:11] src2; [15:0] imm.
  - imm is sign-extended or truncated to DATA_W.
  - Register indices are taken modulo NUM_REGS.
- Opcodes:
  - ALU: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR (logical).
  - Memory: 8 LD (dest=mem[src1+imm]), 9 ST (mem[src1+imm]=src2).
  - Branch: 10 BEQ (pc=imm if zero), 11 BNE, 12 JMP.
  - I/O and control: 13 IN (dest=in_data), 14 OUT (out_data=src1), 15 HALT.
  - 16-31 undefined: set illegal and enter HALT.
- Operand B = imm if imm_flag, else src2 register.
- Shift amount = B[$clog2(DATA_W)-1:0].
- States FETCH -> DECODE -> EXECUTE -> (MEM) -> FETCH; HALT is terminal until reset.
  - FETCH: imem_addr=pc.
  - DECODE: latch imem_rdata into IR; read src1 and src2.
  - EXECUTE: compute; do the writeback or branch; pc updates at the end of EXECUTE.
  - MEM: LD/ST only; EXECUTE computes the address and asserts dmem_req from the next cycle; stay in MEM until dmem_ready; LD writes dest on the ready edge; pc updates then.
- Latency:
  - ALU, branch, IN, OUT, NOP: 3 cycles.
  - LD/ST: 4 + wait cycles (ready in the first MEM cycle = 4 cycles).
- pc increments by 1 and wraps 2^PC_W-1 -> 0. A branch target is imm[PC_W-1:0].
- Flags:
  - Updated only by opcodes 1-7.
  - ADD/SUB carry = carry-out (SUB: borrow = ~carry-out of A+~B+1).
  - Overflow = signed overflow for ADD/SUB, 0 for the others.
  - SHL carry = last bit shifted out; SHR carry = 0.
  - zero = result==0; sign = result MSB.
- Write to r0 has no effect; reading r0 gives 0.
- dmem_req is deasserted the cycle after ready. dmem_req never asserts outside MEM.
- Reset (reset=0 at a clk edge):
  - pc=0; state=FETCH; IR=0.
  - flags, out_data, out_valid, dmem_req, halted, illegal all 0.
  - All registers 0.
  - Reset during MEM drops dmem_req the next cycle; the pending access is abandoned.
- HALT:
  - halted=1; no fetch, memory access or output.
  - imem_addr holds the last pc.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams OP_NOP..OP_HALT;
  - state encoding S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_HALT;
  - instruction field bit positions.
- Sub-module cpu_alu: parametrised by DATA_W. Pure combinational: opcode, a, b -> result, carry, zero, overflow, sign.
- Register file stays inline as an array.

Test Plan:
- ADD imm then ADD reg:
  - Program: r1=r0+5 (ADD imm); r2=r1+r1; OUT r2; HALT.
  - Required: out_data=10 with a single out_valid pulse; halted=1 at cycle 13; flags zero=0.
- Overflow (DATA_W=16):
  - Program: r1=0x7FFF; ADD r1+1.
  - Required: result 0x8000, overflow=1, sign=1, carry=0.
  - Then SUB r0-1: result 0xFFFF, carry=0 (borrow).
- Store/load with waits:
  - Program: ST r1 (0x1234) to address 3; LD r4 from address 3.
  - dmem_ready held low for 2 cycles per access.
  - Required: dmem_req asserted 3 cycles per access, dmem_we=1 then 0, r4=0x1234.
  - Each access takes 6 cycles total.
- Branch and wrap:
  - BNE taken to 0x10 when zero=0; BEQ not taken when zero=0 -> pc+1.
  - pc=255 with NOP -> next fetch at 0 (PC_W=8).
- Error, reset and r0:
  - Opcode 20 -> illegal=1, halted=1, no further imem_addr change.
  - reset=0 pulsed during a MEM wait -> next cycle dmem_req=0, pc=0, illegal=0.
  - Write to r0 then OUT r0 -> out_data=0.
